// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between the fetch and data requesters,
// holding each access for WAIT_CYCLES extra cycles. Define MEM_ARB_RR_EN for round-robin ties.
module mem_arbiter #(
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [15:0] i_addr,
  output logic        i_ready,
  output logic [15:0] i_data,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic        d_ready,
  output logic [15:0] d_rdata,
  input  logic        halt,
  output logic [15:0] m_addr,
  output logic [15:0] m_wdata,
  output logic        m_enable,
  output logic        m_wr,
  output logic        m_dump,
  input  logic [15:0] m_rdata
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACCESS = 3'd1,
    RESP   = 3'd2,
    DUMP   = 3'd3,
    HALTED = 3'd4
  } state_e;

  localparam logic       OWNER_FETCH = 1'b0;
  localparam logic       OWNER_DATA  = 1'b1;
  localparam logic [3:0] WAIT_LAST   = 4'(WAIT_CYCLES);

  state_e      state_q, state_d;
  logic [15:0] addr_q,  addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        wr_q,    wr_d;
  logic        owner_q, owner_d;
  logic [15:0] rdata_q, rdata_d;
  logic [3:0]  cnt_q,   cnt_d;
  logic        grant_data;
  logic        any_req;

`ifdef MEM_ARB_RR_EN
  logic        last_grant_q, last_grant_d;

  // A tie goes to whichever port lost the previous tie; a lone request always wins.
  always_comb begin
    if (i_req && d_req) grant_data = (last_grant_q == OWNER_FETCH);
    else                grant_data = d_req;
  end
`else
  assign grant_data = d_req;
`endif

  assign any_req = i_req | d_req;

  always_comb begin
    // NOTE: every signal assigned here gets its hold value first, so no path can infer a latch.
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    owner_d = owner_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
`ifdef MEM_ARB_RR_EN
    last_grant_d = last_grant_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          owner_d = grant_data ? OWNER_DATA : OWNER_FETCH;
          addr_d  = grant_data ? d_addr : i_addr;
          wdata_d = grant_data ? d_wdata : wdata_q;
          wr_d    = grant_data & d_wr;
          cnt_d   = 4'd0;
          state_d = ACCESS;
`ifdef MEM_ARB_RR_EN
          if (i_req && d_req) last_grant_d = owner_d;
`endif
        end else if (halt) begin
          state_d = DUMP;
        end
      end
      ACCESS: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == WAIT_LAST) begin
          rdata_d = m_rdata;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      DUMP:    state_d = HALTED;
      HALTED:  state_d = HALTED;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      owner_q <= OWNER_FETCH;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      owner_q <= owner_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef MEM_ARB_RR_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) last_grant_q <= OWNER_DATA;
    else      last_grant_q <= last_grant_d;
  end
`endif

  // Outputs decode only from flops, so reset clears them without waiting for a clock.
  assign m_enable = (state_q == ACCESS);
  assign m_wr     = m_enable & wr_q;
  assign m_dump   = (state_q == DUMP);
  assign m_addr   = addr_q;
  assign m_wdata  = wdata_q;
  assign i_ready  = (state_q == RESP) && (owner_q == OWNER_FETCH);
  assign d_ready  = (state_q == RESP) && (owner_q == OWNER_DATA);
  assign i_data   = i_ready ? rdata_q : 16'h0000;
  assign d_rdata  = d_ready ? rdata_q : 16'h0000;

  a_one_ready: assert property (@(posedge clk) disable iff (!rst) !(i_ready && d_ready));
  a_dump_once: assert property (@(posedge clk) disable iff (!rst) m_dump |=> !m_dump);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: three instances (WAIT_CYCLES 1, 0, 3) each on a behavioural memory;
// table vectors, randomized slots against a transaction-level model, halt and reset sequences.
module tb_mem_arbiter;

  localparam int NI = 3;
  localparam int WC [NI] = '{1, 0, 3};

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req    [NI];
  logic [15:0] i_addr   [NI];
  logic        i_ready  [NI];
  logic [15:0] i_data   [NI];
  logic        d_req    [NI];
  logic        d_wr     [NI];
  logic [15:0] d_addr   [NI];
  logic [15:0] d_wdata  [NI];
  logic        d_ready  [NI];
  logic [15:0] d_rdata  [NI];
  logic        halt     [NI];
  logic [15:0] m_addr   [NI];
  logic [15:0] m_wdata  [NI];
  logic        m_enable [NI];
  logic        m_wr     [NI];
  logic        m_dump   [NI];
  logic [15:0] m_rdata  [NI];

  logic [15:0] phys_mem [NI][256];
  logic [15:0] ref_mem  [NI][256];
  int          en_cnt   [NI];
  int          dump_cnt [NI];

  int checks   = 0;
  int failures = 0;
  bit rr_last_d;

  always #5 clk = ~clk;

  function automatic logic [15:0] init_word(input int g, input int a);
    return 16'(16'h1234 + a * 16'h0111 + g * 16'h1000);
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    mem_arbiter #(.WAIT_CYCLES(WC[g])) u_dut (
      .clk      (clk),
      .rst      (rst),
      .i_req    (i_req[g]),
      .i_addr   (i_addr[g]),
      .i_ready  (i_ready[g]),
      .i_data   (i_data[g]),
      .d_req    (d_req[g]),
      .d_wr     (d_wr[g]),
      .d_addr   (d_addr[g]),
      .d_wdata  (d_wdata[g]),
      .d_ready  (d_ready[g]),
      .d_rdata  (d_rdata[g]),
      .halt     (halt[g]),
      .m_addr   (m_addr[g]),
      .m_wdata  (m_wdata[g]),
      .m_enable (m_enable[g]),
      .m_wr     (m_wr[g]),
      .m_dump   (m_dump[g]),
      .m_rdata  (m_rdata[g])
    );

    assign m_rdata[g] = phys_mem[g][m_addr[g][8:1]];

    initial for (int a = 0; a < 256; a++) phys_mem[g][a] <= init_word(g, a);

    always @(posedge clk)
      if (m_enable[g] && m_wr[g]) phys_mem[g][m_addr[g][8:1]] <= m_wdata[g];

    always @(negedge clk) begin
      if (m_enable[g]) en_cnt[g]++;
      if (m_dump[g])   dump_cnt[g]++;
    end
  end

  task automatic check(input string name, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, exp, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    for (int n = 0; n < NI; n++) begin
      i_req[n] = 1'b0; i_addr[n] = '0; d_req[n] = 1'b0; d_wr[n] = 1'b0;
      d_addr[n] = '0;  d_wdata[n] = '0; halt[n] = 1'b0;
    end
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst = 1'b0;
    repeat (2) next_cycle();
    rst = 1'b1;
  endtask

  // Presents requests at relative cycle 0 and watches end_rel cycles; each requester drops
  // its request in the cycle after its ready. Relative ready cycle is -1 when never seen.
  task automatic run_slot(input int n, input bit use_i, input bit use_d, input bit dwr,
                          input logic [15:0] iaddr, input logic [15:0] daddr,
                          input logic [15:0] wdata, input int end_rel,
                          output int got_i, output int got_d,
                          output logic [15:0] got_idata, output logic [15:0] got_ddata,
                          output int nrdy_i, output int nrdy_d, output int en_cycles);
    int en0;
    en0 = en_cnt[n];
    got_i = -1; got_d = -1; got_idata = '0; got_ddata = '0; nrdy_i = 0; nrdy_d = 0;
    i_req[n] = use_i; i_addr[n] = iaddr;
    d_req[n] = use_d; d_wr[n] = dwr; d_addr[n] = daddr; d_wdata[n] = wdata;
    for (int rel = 0; rel < end_rel; rel++) begin
      @(negedge clk);
      if (i_ready[n]) begin
        nrdy_i++;
        if (got_i < 0) begin got_i = rel; got_idata = i_data[n]; end
      end
      if (d_ready[n]) begin
        nrdy_d++;
        if (got_d < 0) begin got_d = rel; got_ddata = d_rdata[n]; end
      end
      next_cycle();
      if (got_i >= 0) i_req[n] = 1'b0;
      if (got_d >= 0) d_req[n] = 1'b0;
    end
    i_req[n] = 1'b0;
    d_req[n] = 1'b0;
    en_cycles = en_cnt[n] - en0;
  endtask

  typedef struct {
    int          n;
    bit          use_i;
    bit          use_d;
    bit          dwr;
    logic [15:0] iaddr;
    logic [15:0] daddr;
    logic [15:0] wdata;
    int          exp_i;
    int          exp_d;
    logic [15:0] exp_idata;
    logic [15:0] exp_ddata;
    int          exp_en;
  } vec_t;

  vec_t vecs [6];

  // One randomized slot on instance 0, expected from transaction order and period arithmetic.
  task automatic random_slot(input int k);
    int pat, w, first, second, e_i, e_d, g_i, g_d, nr_i, nr_d, en;
    bit ui, ud, wr, d_first;
    logic [15:0] ia, da, wd, x_i, x_d, gi_data, gd_data;
    w = WC[0];
    pat = $urandom_range(0, 2);
    ui = (pat != 1); ud = (pat != 0);
    wr = 1'($urandom_range(0, 1));
    ia = 16'($urandom_range(0, 15) * 2);
    da = 16'($urandom_range(0, 15) * 2);
    wd = 16'($urandom);
    first = 2 + w; second = 2 * (w + 3) - 1;
    e_i = -1; e_d = -1; x_i = '0; x_d = '0;
    if (ui && ud) begin
`ifdef MEM_ARB_RR_EN
      d_first = !rr_last_d;
      rr_last_d = d_first;
`else
      d_first = 1'b1;
`endif
    end else begin
      d_first = ud;
    end
    if (!d_first && ui) begin e_i = first; x_i = ref_mem[0][ia[8:1]]; end
    if (ud) begin
      e_d = d_first ? first : second;
      if (wr) ref_mem[0][da[8:1]] = wd;
      else    x_d = ref_mem[0][da[8:1]];
    end
    if (d_first && ui) begin e_i = ud ? second : first; x_i = ref_mem[0][ia[8:1]]; end
    run_slot(0, ui, ud, wr, ia, da, wd, ((e_i > e_d) ? e_i : e_d) + 1,
             g_i, g_d, gi_data, gd_data, nr_i, nr_d, en);
    check($sformatf("rnd%0d_i_rel", k), g_i, e_i);
    check($sformatf("rnd%0d_d_rel", k), g_d, e_d);
    check($sformatf("rnd%0d_en", k), en, (int'(ui) + int'(ud)) * (w + 1));
    if (ui)        check($sformatf("rnd%0d_i_data", k), gi_data, x_i);
    if (ud && !wr) check($sformatf("rnd%0d_d_data", k), gd_data, x_d);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g_i, g_d, nr_i, nr_d, en, d0, e0, dump_rel, late_rdy;
    logic [15:0] gi_data, gd_data;

    idle_inputs();
    rst = 1'b0;
    for (int n = 0; n < NI; n++)
      for (int a = 0; a < 256; a++) ref_mem[n][a] = init_word(n, a);

    // Reset state: every output low for every instance.
    #3;
    for (int n = 0; n < NI; n++) begin
      check($sformatf("reset_ctl%0d", n),
            {m_enable[n], m_wr[n], m_dump[n], i_ready[n], d_ready[n]}, 0);
      check($sformatf("reset_bus%0d", n), {m_addr[n], m_wdata[n], i_data[n], d_rdata[n]}, 0);
    end
    next_cycle();
    next_cycle();
    rst = 1'b1;

    vecs[0] = '{0, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h0010, 16'hBEEF, -1, 3, 16'h0000, 16'h0000, 2};
    vecs[1] = '{0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0010, 16'h0000, -1, 3, 16'h0000, 16'hBEEF, 2};
`ifdef MEM_ARB_RR_EN
    vecs[2] = '{0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0010, 16'h0000, 3, 7, 16'h1234, 16'hBEEF, 4};
`else
    vecs[2] = '{0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0010, 16'h0000, 7, 3, 16'h1234, 16'hBEEF, 4};
`endif
    vecs[3] = '{0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0010, 16'h0000, 7, 3, 16'h1234, 16'hBEEF, 4};
    vecs[4] = '{1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 2, -1, 16'h2234, 16'h0000, 1};
    vecs[5] = '{2, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 5, -1, 16'h3234, 16'h0000, 4};

    foreach (vecs[v]) begin
      run_slot(vecs[v].n, vecs[v].use_i, vecs[v].use_d, vecs[v].dwr, vecs[v].iaddr,
               vecs[v].daddr, vecs[v].wdata,
               ((vecs[v].exp_i > vecs[v].exp_d) ? vecs[v].exp_i : vecs[v].exp_d) + 1,
               g_i, g_d, gi_data, gd_data, nr_i, nr_d, en);
      check($sformatf("vec%0d_i_rel", v), g_i, vecs[v].exp_i);
      check($sformatf("vec%0d_d_rel", v), g_d, vecs[v].exp_d);
      check($sformatf("vec%0d_i_count", v), nr_i, (vecs[v].exp_i >= 0) ? 1 : 0);
      check($sformatf("vec%0d_d_count", v), nr_d, (vecs[v].exp_d >= 0) ? 1 : 0);
      check($sformatf("vec%0d_en", v), en, vecs[v].exp_en);
      if (vecs[v].exp_i >= 0) check($sformatf("vec%0d_i_data", v), gi_data, vecs[v].exp_idata);
      if (vecs[v].exp_d >= 0 && !vecs[v].dwr)
        check($sformatf("vec%0d_d_data", v), gd_data, vecs[v].exp_ddata);
      if (vecs[v].use_d && vecs[v].dwr)
        ref_mem[vecs[v].n][vecs[v].daddr[8:1]] = vecs[v].wdata;
    end

    // Randomized back-to-back slots on instance 0 from a fresh last-grant state.
    apply_reset();
    rr_last_d = 1'b1;
    for (int k = 0; k < 40; k++) random_slot(k);

    // Halt together with a data read: the read completes, then exactly one dump pulse.
    halt[0] = 1'b1;
    run_slot(0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0004, 16'h0000, 4,
             g_i, g_d, gi_data, gd_data, nr_i, nr_d, en);
    check("halt_d_rel", g_d, 3);
    check("halt_d_data", gd_data, ref_mem[0][2]);
    d0 = dump_cnt[0];
    e0 = en_cnt[0];
    dump_rel = -1;
    for (int rel = 4; rel < 10; rel++) begin
      @(negedge clk);
      if (m_dump[0] && dump_rel < 0) dump_rel = rel;
      next_cycle();
    end
    check("halt_dump_rel", dump_rel, 5);
    check("halt_dump_count", dump_cnt[0] - d0, 1);
    check("halt_dump_no_enable", en_cnt[0] - e0, 0);
    run_slot(0, 1'b1, 1'b0, 1'b0, 16'h0008, 16'h0000, 16'h0000, 12,
             g_i, g_d, gi_data, gd_data, nr_i, nr_d, en);
    check("halted_no_i_ready", nr_i, 0);
    check("halted_no_enable", en, 0);
    check("halted_no_second_dump", dump_cnt[0] - d0, 1);

    // Reset in the second ACCESS cycle of a fetch, then a normal re-issued fetch.
    apply_reset();
    i_req[0] = 1'b1;
    i_addr[0] = 16'h0006;
    next_cycle();
    @(negedge clk);
    check("rst_access_enable", m_enable[0], 1);
    next_cycle();
    #2;
    rst = 1'b0;
    #1;
    check("rst_mid_ctl", {m_enable[0], m_wr[0], m_dump[0], i_ready[0], d_ready[0]}, 0);
    check("rst_mid_bus", {m_addr[0], m_wdata[0], i_data[0], d_rdata[0]}, 0);
    i_req[0] = 1'b0;
    late_rdy = 0;
    next_cycle();
    rst = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (i_ready[0] || d_ready[0]) late_rdy++;
      next_cycle();
    end
    check("rst_no_ready", late_rdy, 0);
    run_slot(0, 1'b1, 1'b0, 1'b0, 16'h0006, 16'h0000, 16'h0000, 4,
             g_i, g_d, gi_data, gd_data, nr_i, nr_d, en);
    check("rst_refetch_rel", g_i, 3);
    check("rst_refetch_data", gi_data, ref_mem[0][3]);
    check("rst_refetch_en", en, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
